// File: rtl/alu_seq_core.sv
// Registered MIPS R-type ALU core (AND/OR/ADD/SUB/SLT, iterative SLL/SRL) with a
// one-entry output register and valid/ready handshakes on both sides.
module alu_seq_core #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             out_zero_o,
    output logic             out_ovf_o,
    output logic             out_err_o
);

    localparam logic [5:0] FnAnd = 6'd36;
    localparam logic [5:0] FnOr  = 6'd37;
    localparam logic [5:0] FnAdd = 6'd32;
    localparam logic [5:0] FnSub = 6'd34;
    localparam logic [5:0] FnSlt = 6'd42;
    localparam logic [5:0] FnSll = 6'd0;
    localparam logic [5:0] FnSrl = 6'd2;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [WIDTH-1:0] sum, diff;
    logic             ovf_add, ovf_sub;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_ovf, load_err;

    assign in_ready_o = (state_q == StIdle) && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign sum  = src_a_i + src_b_i;
    assign diff = src_a_i - src_b_i;
    // Signed overflow: operand signs (as seen by the adder) agree but result sign differs.
    assign ovf_add = (src_a_i[WIDTH-1] == src_b_i[WIDTH-1]) && (sum[WIDTH-1] != src_a_i[WIDTH-1]);
    assign ovf_sub = (src_a_i[WIDTH-1] != src_b_i[WIDTH-1]) && (diff[WIDTH-1] != src_a_i[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        load     = 1'b0;
        load_res = '0;
        load_ovf = 1'b0;
        load_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (funct_i)
                        FnAnd: begin load = 1'b1; load_res = src_a_i & src_b_i; end
                        FnOr:  begin load = 1'b1; load_res = src_a_i | src_b_i; end
                        FnAdd: begin load = 1'b1; load_res = sum; load_ovf = ovf_add; end
                        FnSub: begin load = 1'b1; load_res = diff; load_ovf = ovf_sub; end
                        FnSlt: begin
                            load     = 1'b1;
                            load_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
                        end
                        FnSll, FnSrl: begin
                            acc_d   = src_a_i;
                            cnt_d   = shamt_i;
                            left_d  = (funct_i == FnSll);
                            state_d = StShift;
                        end
                        default: begin load = 1'b1; load_err = 1'b1; end
                    endcase
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    acc_d = left_q ? (acc_q << 1) : (acc_q >> 1);
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    load     = 1'b1;
                    load_res = acc_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh load wins over the drain at the same edge.
    always_comb begin
        valid_d  = valid_q && !out_ready_i;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (load) begin
            valid_d  = 1'b1;
            result_d = load_res;
            zero_d   = (load_res == '0);
            ovf_d    = load_ovf;
            err_d    = load_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign out_zero_o  = zero_q;
    assign out_ovf_o   = ovf_q;
    assign out_err_o   = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core: arithmetic/flag vectors, shift latency, backpressure
// and reset abort, with hand-computed expectations.
module tb_alu_seq_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        out_zero, out_ovf, out_err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_core #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .funct_i    (funct),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .shamt_i    (shamt),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .out_zero_o (out_zero),
        .out_ovf_o  (out_ovf),
        .out_err_o  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation for exactly one edge; the core must be ready for it.
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        funct    = f;
        src_a    = a;
        src_b    = b;
        shamt    = sh;
        in_valid = 1'b1;
        #1;
        check_eq({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [31:0] r, input logic z,
                             input logic o, input logic e);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_eq({tag, "_result"}, result, r);
        check_eq({tag, "_zero"}, {31'b0, out_zero}, {31'b0, z});
        check_eq({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, o});
        check_eq({tag, "_err"}, {31'b0, out_err}, {31'b0, e});
    endtask

    // Edges from accept until out_valid rises; 40 means it never did.
    task automatic wait_valid(output int n);
        bit done;
        done = 1'b0;
        n    = 40;
        for (int i = 1; i <= 40; i++) begin
            if (!done) begin
                tick();
                if (out_valid) begin
                    n    = i;
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int lat;
        bit seen;

        rst       = 1'b1;
        in_valid  = 1'b1;
        funct     = 6'd32;
        src_a     = 32'd1;
        src_b     = 32'd1;
        shamt     = '0;
        out_ready = 1'b1;

        tick();
        tick();
        check_eq("rst_no_accept", {31'b0, out_valid}, 32'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags", {29'b0, out_zero, out_ovf, out_err}, 32'd0);
        check_eq("rst_ready", {31'b0, in_ready}, 32'd1);

        issue("add_ovf", 6'd32, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        check_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        issue("sub_zero", 6'd34, 32'd5, 32'd5, 5'd0);
        check_res("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
        issue("sub_ovf", 6'd34, 32'h8000_0000, 32'h0000_0001, 5'd0);
        check_res("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue("slt_neg", 6'd42, 32'h8000_0000, 32'h0000_0001, 5'd0);
        check_res("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
        issue("slt_swap", 6'd42, 32'h0000_0001, 32'h8000_0000, 5'd0);
        check_res("slt_swap", 32'd0, 1'b1, 1'b0, 1'b0);
        issue("or", 6'd37, 32'h1200_0034, 32'h0056_7800, 5'd0);
        check_res("or", 32'h1256_7834, 1'b0, 1'b0, 1'b0);
        issue("bad_funct", 6'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check_res("bad_funct", 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("drain", {31'b0, out_valid}, 32'd0);

        issue("srl31", 6'd2, 32'hF000_0000, 32'hDEAD_BEEF, 5'd31);
        check_eq("srl31_busy", {31'b0, in_ready}, 32'd0);
        wait_valid(lat);
        check_eq("srl31_lat", lat, 32'd32);
        check_res("srl31", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        issue("sll0", 6'd0, 32'hA5A5_A5A5, 32'h0, 5'd0);
        wait_valid(lat);
        check_eq("sll0_lat", lat, 32'd1);
        check_res("sll0", 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);

        issue("sll4", 6'd0, 32'hF000_000F, 32'h0, 5'd4);
        wait_valid(lat);
        check_eq("sll4_lat", lat, 32'd5);
        check_res("sll4", 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
        tick();

        // Backpressure: result held, pending AND stalls until the consumer drains.
        out_ready = 1'b0;
        issue("bp_add", 6'd32, 32'd2, 32'd3, 5'd0);
        funct    = 6'd36;
        src_a    = 32'hFF00_FF00;
        src_b    = 32'h0FF0_0FF0;
        in_valid = 1'b1;
        #1;
        check_eq("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        tick();
        tick();
        check_res("bp_held", 32'd5, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_res("bp_and", 32'h0F00_0F00, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset abort in the middle of a long shift.
        issue("abort_sll", 6'd0, 32'h0000_0001, 32'h0, 5'd10);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("abort_valid", {31'b0, out_valid}, 32'd0);
        check_eq("abort_ready", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_result", {31'b0, seen}, 32'd0);

        issue("post_add", 6'd32, 32'd3, 32'd4, 5'd0);
        check_res("post_add", 32'd7, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
